// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. It owns the program counter, issues one
// instruction-memory fetch at a time over a req/gnt/rvalid handshake, accepts
// redirects from execute, honours decode back-pressure and presents a
// registered {instr, pc, pc+4} bundle to the IF/ID boundary.
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetched and
// perf_squashed counters. With the macro undefined, these ports and counters
// are absent.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_nxpc,
    output logic [31:0] if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        kill;     // the outstanding response belongs to a squashed fetch
    logic        granted;  // a request is accepted this cycle
    logic        resp;     // the response to our outstanding fetch arrives this cycle
    logic        load;     // that response is accepted into the output slot

    // Issue is blocked only while a presented instruction is held by decode.
    assign imem_req  = (state == S_REQ) && !(if_valid && stall);
    assign imem_addr = pc;
    assign granted   = imem_req && imem_gnt;
    // Responses outside WAIT (e.g. a stray response after reset) are ignored.
    assign resp      = (state == S_WAIT) && imem_rvalid;
    assign load      = resp && !kill && !redirect;

    // Sequencer FSM, PC, kill flag and the registered IF/ID bundle.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values. The redirect branch comes last so it overrides
    // anything written earlier in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_nxpc  <= 32'h0;
            if_instr <= 32'h0;
        end else begin
            // Decode consumes the presented instruction.
            if (if_valid && !stall) begin
                if_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (granted) begin
                        state <= S_WAIT;
                        // A redirect alongside a grant means the fetch just issued is stale.
                        if (redirect) begin
                            kill <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state <= S_REQ;
                        kill  <= 1'b0;
                        if (load) begin
                            if_valid <= 1'b1;
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                            if_nxpc  <= pc + 32'd4;
                            pc       <= pc + 32'd4;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A redirect wins over stall and over any load or increment above.
            if (redirect) begin
                pc       <= redirect_pc;
                if_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Count instructions that reach the output slot and responses that are thrown away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched  <= 32'h0;
            perf_squashed <= 32'h0;
        end else begin
            if (load) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (resp && !load) begin
                perf_squashed <= perf_squashed + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. A hand-driven memory grants
// and responds cycle by cycle. Inputs change on the falling edge, and outputs
// are checked 1 ns later, well away from the rising edge.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_nxpc;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    int tests = 0;
    int fails = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_nxpc     (if_nxpc),
        .if_instr    (if_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let them settle.
    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic st, input logic rdr, input logic [31:0] rpc);
        @(negedge clk);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        stall       = st;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
    endtask

    initial begin
        // Reset state.
        @(negedge clk);
        #1;
        check("rst_req",    imem_req,  32'h0);
        check("rst_addr",   imem_addr, 32'h100);
        check("rst_valid",  if_valid,  32'h0);
        check("rst_pc",     if_pc,     32'h0);
        check("rst_nxpc",   if_nxpc,   32'h0);
        check("rst_instr",  if_instr,  32'h0);
        rst = 1'b1;

        // c1: REQ 0x100, granted.
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        check("c1_req",   imem_req,  32'h1);
        check("c1_addr",  imem_addr, 32'h100);
        check("c1_valid", if_valid,  32'h0);
        // c2: WAIT, response arrives.
        drive(0, 1, 32'h0000_0013, 0, 0, 32'h0);
        check("c2_req", imem_req, 32'h0);
        // c3: first instruction presented; 0x104 granted.
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        check("c3_valid", if_valid,  32'h1);
        check("c3_pc",    if_pc,     32'h100);
        check("c3_nxpc",  if_nxpc,   32'h104);
        check("c3_instr", if_instr,  32'h0000_0013);
        check("c3_req",   imem_req,  32'h1);
        check("c3_addr",  imem_addr, 32'h104);
        // c4: consumed, response for 0x104.
        drive(0, 1, 32'h0050_0093, 0, 0, 32'h0);
        check("c4_valid", if_valid, 32'h0);
        check("c4_req",   imem_req, 32'h0);

        // Stall holds the bundle and blocks issue.
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        check("st1_valid", if_valid, 32'h1);
        check("st1_pc",    if_pc,    32'h104);
        check("st1_instr", if_instr, 32'h0050_0093);
        check("st1_req",   imem_req, 32'h0);
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        check("st2_valid", if_valid,  32'h1);
        check("st2_pc",    if_pc,     32'h104);
        check("st2_req",   imem_req,  32'h0);
        check("st2_addr",  imem_addr, 32'h108);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("st3_req",   imem_req, 32'h1);
        check("st3_valid", if_valid, 32'h1);

        // Consumed once; redirect to 0x200 together with the grant of 0x108.
        drive(1, 0, 32'h0, 0, 1, 32'h200);
        check("st4_valid", if_valid,  32'h0);
        check("st4_addr",  imem_addr, 32'h108);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("kg_req",  imem_req,  32'h0);
        check("kg_addr", imem_addr, 32'h200);
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        check("kg_wait", imem_req, 32'h0);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        check("kg_drop",  if_valid,  32'h0);
        check("kg_req2",  imem_req,  32'h1);
        check("kg_addr2", imem_addr, 32'h200);
`ifdef FETCH_PERF_EN
        check("perf_fetched",  perf_fetched,  32'd2);
        check("perf_squashed", perf_squashed, 32'd1);
`endif
        drive(0, 1, 32'h1111_1111, 0, 0, 32'h0);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        check("r2_valid", if_valid,  32'h1);
        check("r2_pc",    if_pc,     32'h200);
        check("r2_nxpc",  if_nxpc,   32'h204);
        check("r2_instr", if_instr,  32'h1111_1111);
        check("r2_addr",  imem_addr, 32'h204);

        // Redirect to 0x300 in the same cycle as the response.
        drive(0, 1, 32'h2222_2222, 0, 1, 32'h300);
        // Then redirect in REQ without a grant, to the top of the address space.
        drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
        check("rv_valid", if_valid,  32'h0);
        check("rv_addr",  imem_addr, 32'h300);
        check("rv_req",   imem_req,  32'h1);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        check("wr_req",  imem_req,  32'h1);
        drive(0, 1, 32'h3333_3333, 0, 0, 32'h0);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        check("wr_valid", if_valid,  32'h1);
        check("wr_pc",    if_pc,     32'hFFFF_FFFC);
        check("wr_nxpc",  if_nxpc,   32'h0);
        check("wr_next",  imem_addr, 32'h0);

        // Reset while WAIT is outstanding, with a stray response around it.
        @(negedge clk);
        rst         = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4444_4444;
        #1;
        check("mr_req",   imem_req,  32'h0);
        check("mr_addr",  imem_addr, 32'h100);
        check("mr_valid", if_valid,  32'h0);
        check("mr_pc",    if_pc,     32'h0);
        check("mr_nxpc",  if_nxpc,   32'h0);
        check("mr_instr", if_instr,  32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 32'h4444_4444, 0, 0, 32'h0);
        check("mr_stray_valid", if_valid,  32'h0);
        check("mr_stray_req",   imem_req,  32'h1);
        check("mr_stray_addr",  imem_addr, 32'h100);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        check("mr_hold_valid", if_valid,  32'h0);
        check("mr_hold_addr",  imem_addr, 32'h100);
        drive(0, 1, 32'h0000_0055, 0, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("mr_fetch_valid", if_valid,  32'h1);
        check("mr_fetch_pc",    if_pc,     32'h100);
        check("mr_fetch_instr", if_instr,  32'h0000_0055);
        check("mr_fetch_addr",  imem_addr, 32'h104);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer that owns the program counter and drives a handshaked instruction-memory port on behalf of the pipeline. It issues one fetch at a time, accepts redirects from the execute stage (branch/jump target), honours back-pressure from the hazard unit, and presents a registered instruction/PC bundle to the IF/ID boundary. It replaces the free-running PC-plus-4 loop wherever instruction memory has variable latency.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-low (0 = in reset).
- redirect  input  1  execute stage requests a fetch redirect this cycle.
- redirect_pc  input  32  redirect target; used unchanged, alignment is execute's responsibility.
- stall  input  1  decode cannot accept the presented instruction this cycle.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address (equals internal PC register).
- imem_gnt  input  1  memory accepts the request this cycle (meaningful only while imem_req=1).
- imem_rvalid  input  1  read data valid; at most one per granted request, earliest one cycle after grant.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  if_pc/if_nxpc/if_instr hold a valid fetched instruction.
- if_pc  output  32  PC of the presented instruction.
- if_nxpc  output  32  if_pc + 4, modulo 2^32.
- if_instr  output  32  presented instruction word.

## Operation
- States: IDLE, REQ, WAIT. Internal regs: pc, kill flag, output bundle.
- IDLE: entered only from reset; next cycle unconditionally -> REQ.
- REQ: imem_req = !(if_valid && stall) (no new fetch while the output slot is held). On imem_req && imem_gnt -> WAIT.
- WAIT: imem_req = 0. On imem_rvalid: if kill, discard data, clear kill; else load if_instr<=imem_rdata, if_pc<=pc, if_nxpc<=pc+4, if_valid<=1, pc<=pc+4. Either way -> REQ.
- Output slot: if_valid clears on a cycle with if_valid && !stall unless reloaded that same edge.
- Redirect (priority over stall and over everything else), always: pc<=redirect_pc, if_valid<=0.
  - IDLE or REQ without grant: stay/go REQ; new address appears on imem_addr next cycle.
  - REQ with grant same cycle: kill<=1, -> WAIT.
  - WAIT without rvalid: kill<=1, stay WAIT.
  - WAIT with rvalid same cycle: response discarded, pc not incremented, kill<=0, -> REQ.
  - Repeated redirects while kill set: pc takes latest target; kill stays 1.
- Arithmetic: all PC math 32-bit unsigned, wraps 32'hFFFFFFFC -> 32'h00000000.
- Memory may see imem_addr change while imem_req=1 without grant (redirect); this is legal on the imem protocol.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_nxpc=0, if_instr=0. Reset mid-transaction abandons the outstanding fetch; a late imem_rvalid arriving in IDLE/REQ is ignored.
- First rising edge after rst release: IDLE->REQ; imem_req=1 from that cycle.
- Latency: grant at cycle N, rvalid at N+k (k>=1) -> if_valid=1 in cycle N+k+1. Next request asserted in cycle N+k+1. Peak throughput one instruction per 2 cycles.
- Redirect at cycle M with no fetch in flight: imem_addr=redirect_pc in cycle M+1.
- stall only blocks issue and holds the output bundle; it never drops an instruction.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32, count of instructions loaded into output slot) and perf_squashed (32, count of responses discarded due to kill); both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, RESET_PC=32'h100, memory grants immediately, rvalid 1 cycle later with 32'h00000013 -> imem_addr 0x100, 0x104, 0x108...; if_valid first high 3 cycles after reset release with if_pc=0x100, if_nxpc=0x104.
- Hold stall=1 while if_valid=1 -> imem_req stays 0, bundle unchanged; release stall -> imem_req=1 next cycle, no instruction lost or duplicated.
- Redirect to 0x200 in same cycle as grant of 0x108 -> response for 0x108 discarded (perf_squashed=1), next request address 0x200, next if_pc=0x200.
- Redirect to 0x300 in same cycle as rvalid -> if_valid=0 next cycle, data dropped, imem_addr=0x300.
- pc=32'hFFFFFFFC fetch -> if_nxpc=0, next imem_addr=0.
- Assert rst low while in WAIT, deliver rvalid during reset and the cycle after release -> all outputs at reset values, stray response ignored, fetch restarts at RESET_PC.
